// File: rtl/approx_mult_pkg.sv
// Shared types and helpers for the approximate-multiplier datapath blocks.
package approx_mult_pkg;

  localparam int PROD_W    = 16;
  localparam int ACC_W_DEF = 24;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // Adds a and b as w-bit unsigned values. ovf reports a carry out of bit w-1;
  // the result either wraps modulo 2^w or clips to 2^w-1 when sat is set.
  // Operands must fit in 63 bits.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w,
                                          input logic        sat,
                                          output logic       ovf);
    logic [64:0] s;
    logic [64:0] lim;
    lim = (65'd1 << w) - 65'd1;
    s   = {1'b0, a} + {1'b0, b};
    ovf = (s > lim);
    if (ovf && sat) s = lim;
    else            s = s & lim;
    return s[63:0];
  endfunction

endpackage

// File: rtl/acc_sat_add.sv
// Combinational accumulator adder with carry detect and optional saturation.
module acc_sat_add import approx_mult_pkg::*; #(
  parameter int ACC_W = ACC_W_DEF,
  parameter int ADD_W = PROD_W + 1,
  parameter bit SAT   = 1'b0
) (
  input  logic [ACC_W-1:0] i_a,
  input  logic [ADD_W-1:0] i_b,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_ovf
);

  // Wide add, then wrap or clip back to the accumulator width.
  always_comb begin
    o_ovf = 1'b0;
    o_sum = ACC_W'(sat_add(64'(i_a), 64'(i_b), ACC_W, SAT, o_ovf));
  end

endmodule

// File: rtl/approx_mac_acc.sv
// Frame accumulator for approximate-multiplier products: sums a frame of
// unsigned products and emits one dot-product result per frame.
// Optional feature macro: APPROX_BIAS_COMP_EN (adds BIAS per product and
// saturates the sum instead of wrapping).
//
// state     | meaning
// ST_ACCUM  | accepting products, summing into r_acc
// ST_HOLD   | frame result presented, waiting for out_ready
module approx_mac_acc #(
  parameter int                PROD_W  = approx_mult_pkg::PROD_W,
  parameter int                ACC_W   = approx_mult_pkg::ACC_W_DEF,
  parameter int                MAX_LEN = 256,
  parameter int                CNT_W   = 9,
  parameter logic [PROD_W-1:0] BIAS    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic [CNT_W-1:0]  out_count,
  output logic              overflow
);
  import approx_mult_pkg::*;

`ifdef APPROX_BIAS_COMP_EN
  localparam bit BIAS_ON = 1'b1;
`else
  localparam bit BIAS_ON = 1'b0;
`endif

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic [ACC_W-1:0]   r_acc_out;
  logic [CNT_W-1:0]   r_cnt_out;
  logic               r_ovf_out;
  logic [ACC_W-1:0]   w_sum;
  logic               w_add_ovf;
  logic [PROD_W:0]    w_addend;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_take;
  logic               w_close;
  logic               w_release;

  // Bias is folded in before the accumulator add so its carry is seen too.
  assign w_addend  = {1'b0, prod} + (BIAS_ON ? {1'b0, BIAS} : '0);
  assign w_take    = in_valid && (r_state == ST_ACCUM);
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_close   = w_take && (in_last || (w_cnt_inc == CNT_W'(MAX_LEN)));
  assign w_release = (r_state == ST_HOLD) && out_ready;

  acc_sat_add #(
    .ACC_W (ACC_W),
    .ADD_W (PROD_W + 1),
    .SAT   (BIAS_ON)
  ) u_add (
    .i_a   (r_acc),
    .i_b   (w_addend),
    .o_sum (w_sum),
    .o_ovf (w_add_ovf)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_ACCUM;
    else     r_state <= w_state_nxt;
  end

  // Next-state: close a frame on last/limit, reopen after the result handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACCUM: if (w_close)   w_state_nxt = ST_HOLD;
      ST_HOLD:  if (out_ready) w_state_nxt = ST_ACCUM;
      default:                 w_state_nxt = ST_ACCUM;
    endcase
  end

  // Running sum, product count and sticky overflow for the open frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_release) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_take) begin
      r_acc <= w_sum;
      r_cnt <= w_cnt_inc;
      r_ovf <= r_ovf | w_add_ovf;
    end
  end

  // Result registers capture the closing product's totals in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_out <= '0;
      r_cnt_out <= '0;
      r_ovf_out <= 1'b0;
    end else if (w_close) begin
      r_acc_out <= w_sum;
      r_cnt_out <= w_cnt_inc;
      r_ovf_out <= r_ovf | w_add_ovf;
    end
  end

  assign in_ready  = (r_state == ST_ACCUM);
  assign out_valid = (r_state == ST_HOLD);
  assign acc_out   = r_acc_out;
  assign out_count = r_cnt_out;
  assign overflow  = r_ovf_out;

endmodule

// File: tb/tb_approx_mac_acc.sv
// Self-checking bench for approx_mac_acc with a frame-level reference model.
module tb_approx_mac_acc;

  localparam int          ACC_W   = 24;
  localparam int          MAX_LEN = 256;
  localparam int          CNT_W   = 9;
  localparam logic [15:0] TB_BIAS = 16'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_big = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] prod = '0;

  logic             in_ready, out_valid, overflow;
  logic [ACC_W-1:0] acc_out;
  logic [CNT_W-1:0] out_count;
  logic             b_in_ready, b_out_valid, b_overflow;
  logic [ACC_W-1:0] b_acc_out;
  logic [9:0]       b_out_count;

  approx_mac_acc #(.PROD_W(16), .ACC_W(ACC_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .BIAS(TB_BIAS)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .prod(prod),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .out_count(out_count), .overflow(overflow));

  approx_mac_acc #(.PROD_W(16), .ACC_W(ACC_W), .MAX_LEN(512), .CNT_W(10), .BIAS(TB_BIAS)) u_big (
    .clk(clk), .rst(rst_big), .in_valid(in_valid), .in_ready(b_in_ready), .prod(prod),
    .in_last(in_last), .out_valid(b_out_valid), .out_ready(out_ready),
    .acc_out(b_acc_out), .out_count(b_out_count), .overflow(b_overflow));

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int n_cyc = 0;
  bit rand_rdy = 1'b0;

  // Reference model: queue of accepted products, pending-result flag, last result.
  bit               m_hold = 1'b0;
  bit               m_take = 1'b0;
  logic [15:0]      q[$];
  logic [ACC_W-1:0] e_acc = '0;
  int               e_cnt = 0;
  bit               e_ovf = 1'b0;

`ifdef APPROX_BIAS_COMP_EN
  localparam int BIAS_ADD = 2;
`else
  localparam int BIAS_ADD = 0;
`endif

  function automatic void frame_sum(input logic [15:0] fq[$], input int w, output longint s, output bit o);
    longint lim;
    lim = (longint'(1) << w) - 1;
    s = 0;
    o = 1'b0;
    foreach (fq[i]) begin
      s += longint'(fq[i]) + longint'(BIAS_ADD);
      if (s > lim) begin
        o = 1'b1;
`ifdef APPROX_BIAS_COMP_EN
        s = lim;
`else
        s -= lim + 1;
`endif
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".in_ready"},  32'(in_ready),  32'(!m_hold));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_hold));
    chk({tag, ".acc_out"},   32'(acc_out),   32'(e_acc));
    chk({tag, ".out_count"}, 32'(out_count), 32'(e_cnt));
    chk({tag, ".overflow"},  32'(overflow),  32'(e_ovf));
  endtask

  task automatic cyc(input string tag);
    longint s;
    bit     o;
    @(posedge clk);
    m_take = 1'b0;
    if (!rst) begin
      if (!m_hold) begin
        if (in_valid) begin
          q.push_back(prod);
          m_take = 1'b1;
          if (in_last || q.size() == MAX_LEN) begin
            frame_sum(q, ACC_W, s, o);
            e_acc = ACC_W'(s);
            e_cnt = q.size();
            e_ovf = o;
            q.delete();
            m_hold = 1'b1;
          end
        end
      end else if (out_ready) begin
        m_hold = 1'b0;
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic send(input logic [15:0] p, input logic last, input string tag);
    in_valid = 1'b1;
    prod     = p;
    in_last  = last;
    for (int k = 0; k < 64; k++) begin
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      cyc(tag);
      n_cyc++;
      if (m_take) break;
    end
    chk({tag, ".accepted"}, 32'(m_take), 32'd1);
  endtask

  task automatic async_reset(input string tag);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    q.delete();
    m_hold = 1'b0;
    e_acc  = '0;
    e_cnt  = 0;
    e_ovf  = 1'b0;
    check_all(tag);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    logic [15:0] p;
    int len;

    // Reset values while held and after release.
    repeat (2) @(posedge clk);
    #1;
    check_all("rst_hold");
    rst = 1'b0;
    cyc("rst_idle");

    // Directed three-product frame.
    out_ready = 1'b1;
    send(16'h0010, 1'b0, "f3");
    send(16'h0020, 1'b0, "f3");
    send(16'h0030, 1'b1, "f3");
    chk("f3.acc_const", 32'(acc_out), 32'h60 + 32'(3 * BIAS_ADD));
    chk("f3.cnt_const", 32'(out_count), 32'd3);
    in_valid = 1'b0;
    cyc("f3.done");

    // Result stall in HOLD with upstream still offering products.
    out_ready = 1'b0;
    send(16'($urandom), 1'b0, "stall");
    send(16'($urandom), 1'b1, "stall");
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      prod = 16'($urandom);
      cyc("stall.hold");
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc("stall.release");
    p = 16'($urandom);
    send(p, 1'b1, "clean");
    chk("clean.acc_const", 32'(acc_out), 32'(p) + 32'(BIAS_ADD));
    chk("clean.cnt_const", 32'(out_count), 32'd1);

    // Force-close at MAX_LEN with full-scale products.
    for (int i = 0; i < 300; i++) begin
      send(16'hFFFF, 1'b0, "maxlen");
      if (i == 255) begin
        chk("maxlen.cnt_const", 32'(out_count), 32'd256);
`ifdef APPROX_BIAS_COMP_EN
        chk("maxlen.acc_const", 32'(acc_out), 32'hFFFFFF);
        chk("maxlen.ovf_const", 32'(overflow), 32'd1);
`else
        chk("maxlen.acc_const", 32'(acc_out), 32'hFFFF00);
        chk("maxlen.ovf_const", 32'(overflow), 32'd0);
`endif
      end
    end

    // Partial frame discarded by reset.
    async_reset("rst_open");
    cyc("rst_open.idle");

    // Reset after 2 of 4 products.
    send(16'h1234, 1'b0, "r24");
    send(16'h0F0F, 1'b0, "r24");
    async_reset("r24.rst");
    cyc("r24.idle");
    send(16'h0001, 1'b1, "r24.next");
    chk("r24.acc_const", 32'(acc_out), 32'd1 + 32'(BIAS_ADD));
    chk("r24.cnt_const", 32'(out_count), 32'd1);

    // Random frames with random out_ready backpressure.
    rand_rdy = 1'b1;
    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) send(16'($urandom), 1'(i == len - 1), "rand");
      in_valid = 1'b0;
      if ($urandom_range(0, 1) == 1) cyc("rand.gap");
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (3) cyc("drain");

    // Back-to-back single-product frames: one result every two cycles.
    n_cyc = 0;
    for (int i = 0; i < 6; i++) begin
      p = 16'($urandom);
      send(p, 1'b1, "b2b");
      chk("b2b.acc_const", 32'(acc_out), 32'(p) + 32'(BIAS_ADD));
    end
    chk("b2b.cycles", 32'(n_cyc), 32'd11);
    in_valid = 1'b0;
    cyc("b2b.done");

    // 257 full-scale products in one frame on the MAX_LEN=512 instance.
    rst = 1'b1;
    rst_big = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      in_valid = 1'b1;
      prod     = 16'hFFFF;
      in_last  = 1'(i == 256);
      chk("big.in_ready", 32'(b_in_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("big.out_valid", 32'(b_out_valid), 32'd1);
    chk("big.cnt", 32'(b_out_count), 32'd257);
    chk("big.ovf", 32'(b_overflow), 32'd1);
`ifdef APPROX_BIAS_COMP_EN
    chk("big.acc", 32'(b_acc_out), 32'hFFFFFF);
`else
    chk("big.acc", 32'(b_acc_out), 32'h00FEFF);
`endif
    @(posedge clk);
    #1;
    chk("big.released", 32'(b_out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
